// File: rtl/snap_pkg.sv
// Shared definitions for the snapshot capture sequencer: state codes,
// control-word field positions and status-word layout.
package snap_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_DELAY   = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DONE    = 3'd4
  } snap_state_e;

  localparam int ARM_BIT   = 0;
  localparam int EXT_BIT   = 1;
  localparam int ABORT_BIT = 2;
  localparam int DLY_LSB   = 16;
  localparam int DLY_MSB   = 27;

  localparam int STS_BUSY_BIT = 0;
  localparam int STS_DONE_BIT = 1;
  localparam int STS_CODE_LSB = 2;
  localparam int STS_CODE_MSB = 4;
  localparam int STS_CNT_LSB  = 16;
  localparam int STS_CNT_MSB  = 31;

  function automatic logic [31:0] build_status(input logic        busy,
                                               input logic        done,
                                               input logic [2:0]  code,
                                               input logic [15:0] count);
    logic [31:0] s;
    s = 32'd0;
    s[STS_BUSY_BIT]               = busy;
    s[STS_DONE_BIT]               = done;
    s[STS_CODE_MSB:STS_CODE_LSB]  = code;
    s[STS_CNT_MSB:STS_CNT_LSB]    = count;
    return s;
  endfunction

endpackage

// File: rtl/snap_trig_ctrl_if.sv
// Host control/status and sample/BRAM write signals of the capture sequencer.
interface snap_trig_ctrl_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic [31:0]       ctrl_word;
  logic [DATA_W-1:0] din;
  logic              din_valid;
  logic              ext_trig;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_data;
  logic              bram_we;
  logic              busy;
  logic              done;
  logic [31:0]       status_word;

  modport master (
    output ctrl_word, din, din_valid, ext_trig,
    input  bram_addr, bram_data, bram_we, busy, done, status_word
  );

  modport slave (
    input  ctrl_word, din, din_valid, ext_trig,
    output bram_addr, bram_data, bram_we, busy, done, status_word
  );
endinterface

// File: rtl/snap_edge_det.sv
// Rising-edge detector; the history register resets high so a level that is
// already asserted when reset releases never produces a pulse.
module snap_edge_det (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_pulse
);

  logic r_q;

  // delayed copy of the input level
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q <= 1'b1;
    end else begin
      r_q <= i_d;
    end
  end

  assign o_pulse = i_d & ~r_q;

endmodule

// File: rtl/snap_trig_ctrl.sv
// Snapshot capture sequencer: arm, wait for trigger, skip a number of valid
// samples, then write exactly 2^ADDR_W valid samples into the buffer.
module snap_trig_ctrl
  import snap_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic          user_clk,
  input  logic          user_rst_n,
  snap_trig_ctrl_if.slave bus
);

  localparam int DELAY_W = DLY_MSB - DLY_LSB + 1;
  localparam logic [ADDR_W:0]    DEPTH   = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]    CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [DELAY_W-1:0] DLY_ONE = {{(DELAY_W-1){1'b0}}, 1'b1};

  logic               w_arm_pulse;
  logic               w_abort;
  logic               w_ext_en;
  logic [DELAY_W-1:0] w_dly;
  logic [ADDR_W:0]    w_count_inc;
  logic               w_unused_ctrl;

  snap_state_e        r_state;
  logic               r_busy;
  logic               r_done;
  logic               r_ext_en;
  logic [DELAY_W-1:0] r_dly_cnt;
  logic [ADDR_W:0]    r_count;
  logic [ADDR_W-1:0]  r_bram_addr;
  logic [DATA_W-1:0]  r_bram_data;
  logic               r_bram_we;
  logic [31:0]        r_status;

  snap_edge_det u_arm_edge (
    .i_clk   (user_clk),
    .i_rst_n (user_rst_n),
    .i_d     (bus.ctrl_word[ARM_BIT]),
    .o_pulse (w_arm_pulse)
  );

  assign w_abort       = bus.ctrl_word[ABORT_BIT];
  assign w_ext_en      = bus.ctrl_word[EXT_BIT];
  assign w_dly         = bus.ctrl_word[DLY_MSB:DLY_LSB];
  assign w_count_inc   = r_count + CNT_ONE;
  assign w_unused_ctrl = ^{bus.ctrl_word[31:DLY_MSB+1], bus.ctrl_word[DLY_LSB-1:ABORT_BIT+1]};

  // sequencer state, counters, buffer write port and status snapshot
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      r_state     <= ST_IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_ext_en    <= 1'b0;
      r_dly_cnt   <= '0;
      r_count     <= '0;
      r_bram_addr <= '0;
      r_bram_data <= '0;
      r_bram_we   <= 1'b0;
      r_status    <= 32'd0;
    end else begin
      r_status  <= build_status(r_busy, r_done, r_state, 16'(r_count));
      r_bram_we <= 1'b0;
      // abort dominates; the count is kept so the host can see how far it got
      if (w_abort) begin
        r_state <= ST_IDLE;
        r_busy  <= 1'b0;
        r_done  <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE, ST_DONE: begin
            if (w_arm_pulse) begin
              r_state   <= ST_ARMED;
              r_busy    <= 1'b1;
              r_done    <= 1'b0;
              r_count   <= '0;
              r_ext_en  <= w_ext_en;
              r_dly_cnt <= w_dly;
            end
          end
          ST_ARMED: begin
            if (!r_ext_en || bus.ext_trig) begin
              r_state <= (r_dly_cnt != '0) ? ST_DELAY : ST_CAPTURE;
            end
          end
          ST_DELAY: begin
            // the sample that empties the counter is skipped, not captured
            if (bus.din_valid) begin
              r_dly_cnt <= r_dly_cnt - DLY_ONE;
              if (r_dly_cnt == DLY_ONE) begin
                r_state <= ST_CAPTURE;
              end
            end
          end
          ST_CAPTURE: begin
            if (bus.din_valid) begin
              r_bram_we   <= 1'b1;
              r_bram_data <= bus.din;
              r_bram_addr <= r_count[ADDR_W-1:0];
              r_count     <= w_count_inc;
              if (w_count_inc == DEPTH) begin
                r_state <= ST_DONE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.bram_addr   = r_bram_addr;
  assign bus.bram_data   = r_bram_data;
  assign bus.bram_we     = r_bram_we;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.status_word = r_status;

endmodule

// File: tb/tb_snap_trig_ctrl.sv
// Randomized bench for snap_trig_ctrl: per-cycle stimulus is recorded and the
// expected write sequence is derived from the capture rules over that record.
module tb_snap_trig_ctrl;

  localparam int AW   = 4;
  localparam int DW   = 32;
  localparam int NCAP = 1 << AW;
  localparam int MAXC = 600;

  logic clk;
  logic rst_n;

  snap_trig_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  snap_trig_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .user_clk   (clk),
    .user_rst_n (rst_n),
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0]   s_ctrl [MAXC];
  logic [DW-1:0] s_din  [MAXC];
  logic          s_vld  [MAXC];
  logic          s_trig [MAXC];
  logic          o_we   [MAXC];
  logic [AW-1:0] o_addr [MAXC];
  logic [DW-1:0] o_data [MAXC];
  logic          o_busy [MAXC];
  logic          o_done [MAXC];
  logic [31:0]   o_sts  [MAXC];
  int n;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // one clock: drive at negedge, record stimulus, sample outputs 1ns after posedge
  task automatic step(input logic [31:0] c, input logic v, input logic t);
    @(negedge clk);
    bus.ctrl_word = c;
    bus.din       = $urandom;
    bus.din_valid = v;
    bus.ext_trig  = t;
    if (n >= MAXC) begin
      $display("FAIL cycle_budget: got %0d expected below %0d", n, MAXC);
      $fatal(1);
    end
    s_ctrl[n] = c; s_din[n] = bus.din; s_vld[n] = v; s_trig[n] = t;
    @(posedge clk);
    #1;
    o_we[n] = bus.bram_we; o_addr[n] = bus.bram_addr; o_data[n] = bus.bram_data;
    o_busy[n] = bus.busy; o_done[n] = bus.done; o_sts[n] = bus.status_word;
    n++;
  endtask

  // one arm/trigger/capture sequence; arm edge is always cycle 1
  task automatic capture_scn(input logic [31:0] cv, input int pct, input int trig_at, input bit glitch);
    int x, e, k, d, last;
    bit found;
    int exp_c[$];
    int obs_c[$];
    logic [31:0] c;
    n = 0;
    step(32'h0, 1'b0, 1'b0);
    for (int i = 1; i < MAXC - 4; i++) begin
      c = cv;
      if (glitch && i == 3) c = cv & ~32'h1;
      step(c, ($urandom_range(99) < pct), (i == trig_at) || (glitch && i == 1));
      if (o_done[n-1]) begin
        step(cv, 1'b1, 1'b0);
        step(cv, 1'b1, 1'b0);
        break;
      end
    end

    // reference: exit from ARMED, then delay valid samples skipped, then NCAP captured
    if (!cv[1]) begin
      x = 2;
    end else begin
      found = 1'b0;
      x = n - 1;
      for (int i = 2; i < n; i++) begin
        if (!found && s_trig[i]) begin
          x = i; found = 1'b1;
        end
      end
    end
    d = int'(cv[27:16]);
    e = x; k = 0;
    while (k < d && e < n - 1) begin
      e++;
      if (s_vld[e]) k++;
    end
    for (int i = e + 1; i < n && exp_c.size() < NCAP; i++)
      if (s_vld[i]) exp_c.push_back(i);
    for (int i = 0; i < n; i++)
      if (o_we[i]) obs_c.push_back(i);

    check_val("arm_busy", 32'(o_busy[1]), 32'd1);
    check_val("arm_done_clr", 32'(o_done[1]), 32'd0);
    check_val("arm_status", o_sts[2], 32'h0000_0005);
    check_val("n_writes", obs_c.size(), NCAP);
    for (int i = 0; i < obs_c.size() && i < exp_c.size(); i++) begin
      check_val("wr_cycle", obs_c[i], exp_c[i]);
      check_val("wr_addr", 32'(o_addr[obs_c[i]]), i);
      check_val("wr_data", o_data[obs_c[i]], s_din[exp_c[i]]);
    end
    if (exp_c.size() == NCAP && n > exp_c[NCAP-1] + 2) begin
      last = exp_c[NCAP-1];
      check_val("done_set", 32'(o_done[last]), 32'd1);
      check_val("busy_clr", 32'(o_busy[last]), 32'd0);
      check_val("done_status", o_sts[last+1], (NCAP << 16) | (4 << 2) | 2);
      check_val("addr_hold", 32'(o_addr[last+2]), NCAP - 1);
    end else begin
      check_val("capture_complete", exp_c.size(), NCAP);
    end
  endtask

  initial begin
    logic [31:0] cv;
    int wr7;
    bus.ctrl_word = 32'h1;
    bus.din       = '0;
    bus.din_valid = 1'b0;
    bus.ext_trig  = 1'b0;
    rst_n = 1'b0;
    n = 0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_addr", 32'(bus.bram_addr), 32'd0);
    check_val("rst_data", bus.bram_data, 32'd0);
    check_val("rst_we", 32'(bus.bram_we), 32'd0);
    check_val("rst_busy", 32'(bus.busy), 32'd0);
    check_val("rst_done", 32'(bus.done), 32'd0);
    check_val("rst_status", bus.status_word, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // arm bit held high across reset release must not arm
    for (int i = 0; i < 4; i++) step(32'h1, 1'b1, 1'b1);
    check_val("held_arm_busy", 32'(o_busy[n-1]), 32'd0);
    check_val("held_arm_status", o_sts[n-1], 32'd0);

    capture_scn(32'h0000_0001, 100, 0, 1'b0);
    capture_scn(32'h0000_0001, 100, 0, 1'b0);
    capture_scn(32'h0005_0003, 100, 8, 1'b1);
    capture_scn(32'h0000_0003, 100, 5, 1'b0);
    capture_scn(32'h0003_0001, 50, 0, 1'b0);
    for (int r = 0; r < 5; r++) begin
      cv = {4'($urandom), 12'($urandom_range(0, 6)), 13'd0, 1'b0, 1'($urandom), 1'b1};
      capture_scn(cv, 50, $urandom_range(2, 12), 1'($urandom));
    end

    // abort after 7 writes: capture cycles 3..9 at full valid rate
    n = 0;
    step(32'h0, 1'b1, 1'b0);
    for (int i = 1; i <= 9; i++) step(32'h1, 1'b1, 1'b0);
    step(32'h5, 1'b1, 1'b0);
    wr7 = 0;
    for (int i = 0; i < n; i++) if (o_we[i]) wr7++;
    check_val("abort_prior_writes", wr7, 32'd7);
    check_val("abort_we", 32'(o_we[n-1]), 32'd0);
    check_val("abort_busy", 32'(o_busy[n-1]), 32'd0);
    check_val("abort_done", 32'(o_done[n-1]), 32'd0);
    step(32'h5, 1'b1, 1'b0);
    check_val("abort_status", o_sts[n-1], 32'h0007_0000);
    for (int i = 0; i < 3; i++) step(32'h1, 1'b1, 1'b0);
    check_val("post_abort_no_arm", 32'(o_busy[n-1]), 32'd0);
    capture_scn(32'h0002_0001, 100, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
